// File: rtl/riscv_tag_store_unit.sv
// EX-stage tag writer: computes the store's destination tag and writes it to tag memory,
// stalling EX while the write is outstanding, and flags tainted store addresses.
module riscv_tag_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  is_store_i,
    input  logic                  enable_a_i,
    input  logic                  enable_b_i,
    input  logic                  check_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  rs1_tag_i,
    input  logic                  rs2_tag_i,
    output logic                  ex_ready_o,
    output logic                  tag_exception_o,
    output logic                  tag_req_o,
    input  logic                  tag_gnt_i,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic                  tag_we_o,
    output logic                  tag_wdata_o,
    input  logic                  tag_rvalid_i,
    input  logic                  tag_err_i,
    output logic                  tag_bus_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RV = 2'd2
    } state_t;

    state_t                  state;
    logic                    store_req;
    logic                    violation;
    logic                    tag_bit;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign store_req = ex_valid_i & is_store_i;
    assign violation = store_req & check_en_i & rs1_tag_i;
    assign tag_bit   = (enable_a_i & rs1_tag_i) | (enable_b_i & rs2_tag_i);
    assign word_addr = addr_i & ~ADDR_WIDTH'(3);

    // Every request is a write, so the write enable is the request flop itself.
    assign tag_we_o = tag_req_o;

    always_comb begin
        ex_ready_o      = 1'b1;
        tag_exception_o = 1'b0;
        case (state)
            IDLE: begin
                tag_exception_o = violation;
                ex_ready_o      = violation | ~store_req;
            end
            REQ:     ex_ready_o = tag_gnt_i;
            WAIT_RV: ex_ready_o = ~store_req;
            default: ex_ready_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tag_req_o     <= 1'b0;
            tag_addr_o    <= '0;
            tag_wdata_o   <= 1'b0;
            tag_bus_err_o <= 1'b0;
        end else begin
            tag_bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_req && !violation) begin
                        state       <= REQ;
                        tag_req_o   <= 1'b1;
                        tag_addr_o  <= word_addr;
                        tag_wdata_o <= tag_bit;
                    end
                end
                REQ: begin
                    if (tag_gnt_i) begin
                        state     <= WAIT_RV;
                        tag_req_o <= 1'b0;
                    end
                end
                WAIT_RV: begin
                    if (tag_rvalid_i) begin
                        state         <= IDLE;
                        tag_bus_err_o <= tag_err_i;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tag_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_tag_store_unit.sv
// Directed table-driven bench for riscv_tag_store_unit plus a hand-written reset-in-REQ sequence.
module tb_riscv_tag_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i, is_store_i, enable_a_i, enable_b_i, check_en_i;
    logic [31:0] addr_i;
    logic        rs1_tag_i, rs2_tag_i;
    logic        ex_ready_o, tag_exception_o, tag_req_o;
    logic        tag_gnt_i;
    logic [31:0] tag_addr_o;
    logic        tag_we_o, tag_wdata_o;
    logic        tag_rvalid_i, tag_err_i;
    logic        tag_bus_err_o;

    int unsigned n_vec;
    int unsigned n_bad;

    riscv_tag_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_i      (ex_valid_i),
        .is_store_i      (is_store_i),
        .enable_a_i      (enable_a_i),
        .enable_b_i      (enable_b_i),
        .check_en_i      (check_en_i),
        .addr_i          (addr_i),
        .rs1_tag_i       (rs1_tag_i),
        .rs2_tag_i       (rs2_tag_i),
        .ex_ready_o      (ex_ready_o),
        .tag_exception_o (tag_exception_o),
        .tag_req_o       (tag_req_o),
        .tag_gnt_i       (tag_gnt_i),
        .tag_addr_o      (tag_addr_o),
        .tag_we_o        (tag_we_o),
        .tag_wdata_o     (tag_wdata_o),
        .tag_rvalid_i    (tag_rvalid_i),
        .tag_err_i       (tag_err_i),
        .tag_bus_err_o   (tag_bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, s, ea, eb, ck;
        logic [31:0] addr;
        logic        t1, t2, gnt, rv, err;
        logic        rdy, exc, req;
        logic [31:0] aout;
        logic        wd, be;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, s, ea, eb, ck, input logic [31:0] addr,
                       input logic t1, t2, gnt, rv, err,
                       input logic rdy, exc, req, input logic [31:0] aout,
                       input logic wd, be);
        vec_t r;
        r.v = v; r.s = s; r.ea = ea; r.eb = eb; r.ck = ck; r.addr = addr;
        r.t1 = t1; r.t2 = t2; r.gnt = gnt; r.rv = rv; r.err = err;
        r.rdy = rdy; r.exc = exc; r.req = req; r.aout = aout; r.wd = wd; r.be = be;
        vecs.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        ex_valid_i = r.v; is_store_i = r.s; enable_a_i = r.ea; enable_b_i = r.eb;
        check_en_i = r.ck; addr_i = r.addr; rs1_tag_i = r.t1; rs2_tag_i = r.t2;
        tag_gnt_i = r.gnt; tag_rvalid_i = r.rv; tag_err_i = r.err;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        n_vec = 0;
        n_bad = 0;
        idle = '{v:0, s:0, ea:0, eb:0, ck:0, addr:0, t1:0, t2:0, gnt:0, rv:0, err:0,
                 rdy:0, exc:0, req:0, aout:0, wd:0, be:0};
        rst_n = 1'b0;
        drive(idle);

        //  v s ea eb ck addr          t1 t2 g rv er   rdy exc req aout          wd be
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h0,         0,0); // reset state
        // store with enable_a, immediate grant
        add(1,1,1,0,0, 32'h1007,      1,0,0,0,0,     0,0,0, 32'h0,         0,0);
        add(1,1,1,0,0, 32'h1007,      1,0,1,0,0,     1,0,1, 32'h1004,      1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,1,0,     1,0,0, 32'h1004,      1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h1004,      1,0);
        // store with enable_b, grant delayed 3 cycles, errored response
        add(1,1,0,1,0, 32'h2000,      0,1,0,0,0,     0,0,0, 32'h1004,      1,0);
        add(1,1,0,1,0, 32'h2000,      0,1,0,0,0,     0,0,1, 32'h2000,      1,0);
        add(1,1,0,1,0, 32'h2000,      0,1,0,0,0,     0,0,1, 32'h2000,      1,0);
        add(1,1,0,1,0, 32'h2000,      0,1,0,0,0,     0,0,1, 32'h2000,      1,0);
        add(1,1,0,1,0, 32'h2000,      0,1,1,0,0,     1,0,1, 32'h2000,      1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,1,1,     1,0,0, 32'h2000,      1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h2000,      1,1);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h2000,      1,0);
        // tainted address with checking enabled: exception, no request
        add(1,1,1,0,1, 32'h3000,      1,0,0,0,0,     1,1,0, 32'h2000,      1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h2000,      1,0);
        // store, ALU op, store; rvalid two cycles after grant
        add(1,1,1,1,0, 32'h40,        0,0,0,0,0,     0,0,0, 32'h2000,      1,0);
        add(1,1,1,1,0, 32'h40,        0,0,1,0,0,     1,0,1, 32'h40,        0,0);
        add(1,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h40,        0,0);
        add(1,1,1,0,0, 32'h85,        1,0,0,1,0,     0,0,0, 32'h40,        0,0);
        add(1,1,1,0,0, 32'h85,        1,0,0,0,0,     0,0,0, 32'h40,        0,0);
        add(1,1,1,0,0, 32'h85,        1,0,1,0,0,     1,0,1, 32'h84,        1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,1,0,     1,0,0, 32'h84,        1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h84,        1,0);
        // stray rvalid in IDLE is ignored
        add(0,0,0,0,0, 32'h0,         0,0,0,1,1,     1,0,0, 32'h84,        1,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h84,        1,0);
        // violating store waits out WAIT_RV, exception only once back in IDLE
        add(1,1,0,0,0, 32'h100,       0,0,0,0,0,     0,0,0, 32'h84,        1,0);
        add(1,1,0,0,0, 32'h100,       0,0,1,0,0,     1,0,1, 32'h100,       0,0);
        add(1,1,1,0,1, 32'h200,       1,0,0,0,0,     0,0,0, 32'h100,       0,0);
        add(1,1,1,0,1, 32'h200,       1,0,0,1,0,     0,0,0, 32'h100,       0,0);
        add(1,1,1,0,1, 32'h200,       1,0,0,0,0,     1,1,0, 32'h100,       0,0);
        add(0,0,0,0,0, 32'h0,         0,0,0,0,0,     1,0,0, 32'h100,       0,0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            logic [37:0] act, exp;
            @(posedge clk);
            #1 drive(vecs[i]);
            #3;
            act = {ex_ready_o, tag_exception_o, tag_req_o, tag_we_o, tag_addr_o, tag_wdata_o, tag_bus_err_o};
            exp = {vecs[i].rdy, vecs[i].exc, vecs[i].req, vecs[i].req, vecs[i].aout, vecs[i].wd, vecs[i].be};
            n_vec++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL vec%0d {rdy,exc,req,we,addr,wd,be}: got %0b_%0b_%0b_%0b_%h_%0b_%0b expected %0b_%0b_%0b_%0b_%h_%0b_%0b",
                         i, act[37], act[36], act[35], act[34], act[33:2], act[1], act[0],
                         exp[37], exp[36], exp[35], exp[34], exp[33:2], exp[1], exp[0]);
            end
        end

        // reset asserted while in REQ drops the request at once
        @(posedge clk);
        #1 drive(idle);
        ex_valid_i = 1; is_store_i = 1; enable_a_i = 1; rs1_tag_i = 1; addr_i = 32'h503;
        #3 chk("rst_accept_ready", 32'(ex_ready_o), 32'h0);
        @(posedge clk);
        #4 chk("rst_in_req", 32'(tag_req_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_cleared", 32'(tag_req_o), 32'h0);
        chk("rst_we_cleared", 32'(tag_we_o), 32'h0);
        chk("rst_addr_cleared", tag_addr_o, 32'h0);
        chk("rst_wdata_cleared", 32'(tag_wdata_o), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3 chk("post_rst_accept_ready", 32'(ex_ready_o), 32'h0);
        chk("post_rst_req_idle", 32'(tag_req_o), 32'h0);
        @(posedge clk);
        #1 tag_gnt_i = 1;
        #3 chk("post_rst_req", 32'(tag_req_o), 32'h1);
        chk("post_rst_addr", tag_addr_o, 32'h500);
        chk("post_rst_wdata", 32'(tag_wdata_o), 32'h1);
        chk("post_rst_ready", 32'(ex_ready_o), 32'h1);
        @(posedge clk);
        #1 drive(idle);
        tag_rvalid_i = 1;
        #3 chk("post_rst_wait_req", 32'(tag_req_o), 32'h0);
        @(posedge clk);
        #1 drive(idle);
        #3 chk("post_rst_bus_err", 32'(tag_bus_err_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
